// File: rtl/mdu_unit_pkg.sv
// Shared constants and types for the multiply/divide unit.
// Holds the MDUType command encodings, the default latencies, the FSM state
// type and the packed HI/LO result payload.
package mdu_unit_pkg;

    // Command codes driven by the E-stage decoder
    localparam logic [4:0] MDUType_mfhi  = 5'd0;
    localparam logic [4:0] MDUType_mflo  = 5'd1;
    localparam logic [4:0] MDUType_mthi  = 5'd2;
    localparam logic [4:0] MDUType_mtlo  = 5'd3;
    localparam logic [4:0] MDUType_mult  = 5'd4;
    localparam logic [4:0] MDUType_multu = 5'd5;
    localparam logic [4:0] MDUType_div   = 5'd6;
    localparam logic [4:0] MDUType_divu  = 5'd7;
    localparam logic [4:0] MDUType_none  = 5'd31;

    // Default busy latencies
    localparam int unsigned MULT_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF  = 10;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } mdu_state_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } mdu_result_t;

    // True for the four commands that launch a multi-cycle operation
    function automatic logic is_start_op(input logic [4:0] op);
        return (op == MDUType_mult) || (op == MDUType_multu) ||
               (op == MDUType_div)  || (op == MDUType_divu);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit product and quotient/remainder datapath.
// Ports:
//   is_div_i      1 = divide, 0 = multiply
//   is_signed_i   1 = two's-complement operands
//   a_i, b_i      32-bit operands (dividend / divisor for divide)
//   res_c_o       {hi, lo}: product split, or {remainder, quotient}
//   div_zero_c_o  divide with b_i == 0; res_c_o is meaningless then
module mdu_arith
    import mdu_unit_pkg::*;
(
    input  logic        is_div_i,
    input  logic        is_signed_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output mdu_result_t res_c_o,
    output logic        div_zero_c_o
);

    logic        a_neg;
    logic        b_neg;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_div;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    // Signed ops run on magnitudes; signs are restored afterwards so the
    // quotient truncates toward zero and the remainder follows the dividend.
    always_comb begin
        a_neg = is_signed_i & a_i[31];
        b_neg = is_signed_i & b_i[31];

        // Low 64 bits of a sign-extended product equal the signed product
        a_ext = {{32{a_neg}}, a_i};
        b_ext = {{32{b_neg}}, b_i};
        prod  = a_ext * b_ext;

        a_mag = a_neg ? 32'(-a_i) : a_i;
        b_mag = b_neg ? 32'(-b_i) : b_i;
        // Keep the divider defined on a zero divisor; the result is discarded
        b_div = (b_i == 32'd0) ? 32'd1 : b_mag;
        q_mag = a_mag / b_div;
        r_mag = a_mag % b_div;

        if (is_div_i) begin
            res_c_o.lo = (a_neg ^ b_neg) ? 32'(-q_mag) : q_mag;
            res_c_o.hi = a_neg ? 32'(-r_mag) : r_mag;
        end else begin
            res_c_o.hi = prod[63:32];
            res_c_o.lo = prod[31:0];
        end

        div_zero_c_o = is_div_i & (b_i == 32'd0);
    end

endmodule

// File: rtl/mdu_unit.sv
// Multiply/divide responder on the E-stage command interface.
// Owns HI/LO, models mult/div latency with a busy countdown, and returns
// mfhi/mflo data on MDUO.
// Ports:
//   clk, reset     rising-edge clock, synchronous active-low reset
//   MDUType, req   command code and E-stage valid
//   A, B           forwarded rs / rt
//   start          comb: valid mult/multu/div/divu this cycle
//   busy           operation in flight
//   HI, LO         architectural registers
//   MDUO           comb: HI on mfhi, LO on mflo, else 0
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  MDUType,
    input  logic        req,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUO
);

    localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    mdu_result_t        tmp_q, tmp_d;
    logic               wr_q, wr_d;

    logic               is_div;
    logic               is_signed;
    mdu_result_t        arith_res;
    logic               div_zero;

    mdu_arith u_arith (
        .is_div_i     (is_div),
        .is_signed_i  (is_signed),
        .a_i          (A),
        .b_i          (B),
        .res_c_o      (arith_res),
        .div_zero_c_o (div_zero)
    );

    // State register; reset discards any in-flight result
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            tmp_q   <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            tmp_q   <= tmp_d;
            wr_q    <= wr_d;
        end
    end

    // Next-state and combinational outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        tmp_d     = tmp_q;
        wr_d      = wr_q;

        start     = req & is_start_op(MDUType);
        is_div    = (MDUType == MDUType_div)  || (MDUType == MDUType_divu);
        is_signed = (MDUType == MDUType_mult) || (MDUType == MDUType_div);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    tmp_d   = arith_res;
                    // Divide by zero still burns the full latency but commits nothing
                    wr_d    = ~div_zero;
                    cnt_d   = is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
                    state_d = S_RUN;
                end else if (req && (MDUType == MDUType_mthi)) begin
                    hi_d = A;
                end else if (req && (MDUType == MDUType_mtlo)) begin
                    lo_d = A;
                end
            end
            S_RUN: begin
                // Commands arriving here are ignored; upstream must stall them
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    if (wr_q) begin
                        hi_d = tmp_q.hi;
                        lo_d = tmp_q.lo;
                    end
                end
            end
        endcase

        if (MDUType == MDUType_mfhi) begin
            MDUO = hi_q;
        end else if (MDUType == MDUType_mflo) begin
            MDUO = lo_q;
        end else begin
            MDUO = 32'd0;
        end
    end

    assign busy = (state_q == S_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: the driver computes the expected outputs for
// every cycle from a plain-arithmetic model and queues them; a monitor on the
// falling edge pops and compares against the DUT.
module tb_mdu_unit;
    import mdu_unit_pkg::*;

    localparam int unsigned MLAT = 5;
    localparam int unsigned DLAT = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  MDUType;
    logic        req;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDUO;

    always #5 clk = ~clk;

    mdu_unit #(
        .MULT_LAT (MLAT),
        .DIV_LAT  (DLAT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .MDUType (MDUType),
        .req     (req),
        .A       (A),
        .B       (B),
        .start   (start),
        .busy    (busy),
        .HI      (HI),
        .LO      (LO),
        .MDUO    (MDUO)
    );

    typedef struct {
        logic        start;
        logic        busy;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] mduo;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    // Reference model: architectural state plus a pending result and countdown
    logic [31:0] m_hi, m_lo, m_thi, m_tlo;
    int          m_rem   = 0;
    bit          m_wr    = 1'b0;
    bit          m_valid = 1'b0;

    task automatic chk(input string name, input int c, input logic [31:0] act,
                       input logic [31:0] req_v);
        n_cmp++;
        if (act !== req_v) begin
            n_err++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, c, act, req_v);
        end
    endtask

    // Drive one cycle: queue expected outputs, advance the model, clock the DUT
    task automatic step(input bit rst_n, input bit r, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] p;
        longint      sa, sb, q, rm;
        reset   = rst_n;
        req     = r;
        MDUType = op;
        A       = a;
        B       = b;
        if (m_valid) begin
            e.start = r && (op >= 5'd4) && (op <= 5'd7);
            e.busy  = (m_rem > 0);
            e.hi    = m_hi;
            e.lo    = m_lo;
            e.mduo  = (op == 5'd0) ? m_hi : (op == 5'd1) ? m_lo : 32'd0;
            e.cyc   = cyc;
            sb_q.push_back(e);
        end
        if (!rst_n) begin
            m_hi = 0; m_lo = 0; m_thi = 0; m_tlo = 0;
            m_rem = 0; m_wr = 0; m_valid = 1;
        end else if (m_valid) begin
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0 && m_wr) begin
                    m_hi = m_thi;
                    m_lo = m_tlo;
                end
            end else if (r) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                case (op)
                    5'd2: m_hi = a;
                    5'd3: m_lo = a;
                    5'd4: begin
                        p = 64'(sa * sb);
                        m_thi = p[63:32]; m_tlo = p[31:0];
                        m_rem = MLAT; m_wr = 1;
                    end
                    5'd5: begin
                        p = {32'd0, a} * {32'd0, b};
                        m_thi = p[63:32]; m_tlo = p[31:0];
                        m_rem = MLAT; m_wr = 1;
                    end
                    5'd6: begin
                        m_rem = DLAT; m_wr = (b != 0);
                        if (b != 0) begin
                            q = sa / sb; rm = sa % sb;
                            m_tlo = 32'(q); m_thi = 32'(rm);
                        end
                    end
                    5'd7: begin
                        m_rem = DLAT; m_wr = (b != 0);
                        if (b != 0) begin
                            m_tlo = a / b; m_thi = a % b;
                        end
                    end
                    default: ;
                endcase
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, MDUType_none, 32'd0, 32'd0);
    endtask

    task automatic cmd(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        step(1, 1, op, a, b);
    endtask

    // Monitor: one queued expectation per cycle, checked mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("start", e.cyc, 32'(start), 32'(e.start));
            chk("busy",  e.cyc, 32'(busy),  32'(e.busy));
            chk("HI",    e.cyc, HI,   e.hi);
            chk("LO",    e.cyc, LO,   e.lo);
            chk("MDUO",  e.cyc, MDUO, e.mduo);
        end
    end

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            4: return 32'(-$urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [4:0] op;
        reset   = 1'b0;
        req     = 1'b0;
        MDUType = MDUType_none;
        A       = 32'd0;
        B       = 32'd0;
        #1;
        step(0, 0, MDUType_none, 0, 0);
        step(0, 0, MDUType_none, 0, 0);
        idle(1);

        // Signed / unsigned multiply of -2 by 3
        cmd(MDUType_mult, 32'hFFFF_FFFE, 32'd3);
        idle(MLAT);
        cmd(MDUType_mfhi, 0, 0);
        cmd(MDUType_mflo, 0, 0);
        cmd(MDUType_multu, 32'hFFFF_FFFE, 32'd3);
        idle(MLAT + 1);

        // Signed and unsigned divide
        cmd(MDUType_div, 32'hFFFF_FFF9, 32'd2);
        idle(DLAT + 1);
        cmd(MDUType_divu, 32'd7, 32'd2);
        idle(DLAT + 1);

        // Divide by zero leaves preset HI/LO alone
        cmd(MDUType_mthi, 32'h11, 0);
        cmd(MDUType_mtlo, 32'h22, 0);
        cmd(MDUType_div, 32'd5, 32'd0);
        idle(DLAT);
        cmd(MDUType_mfhi, 0, 0);
        cmd(MDUType_mflo, 0, 0);

        // Second mult issued while busy is ignored
        cmd(MDUType_mult, 32'd1234, 32'd5678);
        idle(1);
        cmd(MDUType_mult, 32'd9, 32'd9);
        idle(MLAT);

        // Reset in the middle of a divide
        cmd(MDUType_div, 32'd100, 32'd7);
        idle(2);
        step(0, 0, MDUType_none, 0, 0);
        idle(1);
        cmd(MDUType_mfhi, 0, 0);

        // mthi then mfhi; req=0 on a mult code does nothing
        cmd(MDUType_mthi, 32'hDEAD_BEEF, 0);
        cmd(MDUType_mfhi, 0, 0);
        step(1, 0, MDUType_mult, 32'd3, 32'd4);
        idle(1);

        // Overflowing signed divide
        cmd(MDUType_div, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(DLAT);
        cmd(MDUType_mfhi, 0, 0);
        cmd(MDUType_mflo, 0, 0);

        // Random traffic, including commands issued while busy
        for (int i = 0; i < 1500; i++) begin
            op = ($urandom_range(0, 9) < 6) ? 5'($urandom_range(0, 7))
                                            : 5'($urandom_range(0, 31));
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 8),
                 op, rand_opnd(), rand_opnd());
        end
        idle(2);

        #10;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain actual=%0d required=0 expectations left", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
